// File: rtl/bufr_reset_sequencer_if.sv
// bufr_reset_sequencer_if
//   Bundles the control and status signals of the regional-buffer reset
//   sequencer.
//   master : the controlling side. It drives start/stop/locked and observes
//            the buffer controls and status.
//   slave  : the sequencer itself.
//   Signals:
//     start, stop   single-cycle bring-up / shutdown requests
//     locked        source-clock lock (asynchronous to clk)
//     bufr_clr      regional buffer divider clear
//     bufr_ce       regional buffer clock enable
//     serdes_rst    reset to SERDES logic on the divided clock
//     ready         divided clock valid, SERDES out of reset
//     busy          sequence in progress
//     timeout       sticky lock-timeout flag
interface bufr_reset_sequencer_if;
  logic start;
  logic stop;
  logic locked;
  logic bufr_clr;
  logic bufr_ce;
  logic serdes_rst;
  logic ready;
  logic busy;
  logic timeout;

  modport master (
    output start, stop, locked,
    input  bufr_clr, bufr_ce, serdes_rst, ready, busy, timeout
  );

  modport slave (
    input  start, stop, locked,
    output bufr_clr, bufr_ce, serdes_rst, ready, busy, timeout
  );
endinterface

// File: rtl/bufr_reset_sequencer.sv
// bufr_reset_sequencer
//   Brings up a regional clock buffer (BUFR) and the SERDES logic behind it.
//   The sequence is: wait for source lock, hold the divider clear, release
//   it, wait, enable the buffer clock, hold the SERDES reset, then report
//   ready. If lock is lost, the sequence restarts from the lock wait. A stop
//   request returns the block to idle.
//   Ports:
//     clk    free-running reference clock, independent of the buffered clock
//     CLR    asynchronous, active-high reset
//     bus    bufr_reset_sequencer_if.slave (start/stop/locked in,
//            bufr_clr/bufr_ce/serdes_rst/ready/busy/timeout out)
//   Optional feature: define BUFR_SEQ_TIMEOUT_EN to abort the lock wait after
//   LOCK_TIMEOUT cycles and raise the sticky timeout flag. Without the macro,
//   the lock wait is unbounded and timeout is tied low.
module bufr_reset_sequencer #(
  parameter int unsigned CLR_CYCLES        = 4,
  parameter int unsigned CE_DELAY          = 2,
  parameter int unsigned SERDES_RST_CYCLES = 8,
  parameter int unsigned LOCK_TIMEOUT      = 1024
) (
  input logic                   clk,
  input logic                   CLR,
  bufr_reset_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOCK,
    CLR_HOLD,
    CE_WAIT,
    SERDES_RST,
    READY
  } state_t;

  localparam logic [15:0] CLR_LAST  = 16'(CLR_CYCLES - 1);
  localparam logic [15:0] CE_LAST   = 16'(CE_DELAY - 1);
  localparam logic [15:0] SRST_LAST = 16'(SERDES_RST_CYCLES - 1);

  state_t      state, next_state;
  logic [15:0] cnt;
  logic [1:0]  lock_sync;
  logic        lock;
  logic        clr_q, ce_q, srst_q, ready_q, busy_q;

  assign lock = lock_sync[1];

`ifdef BUFR_SEQ_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(LOCK_TIMEOUT - 1);
  logic timeout_q, timeout_nxt;
`endif

  // Next-state logic. Stop takes priority over everything. Lock loss takes
  // priority over the dwell-counter expiry in each post-lock state.
  always_comb begin
    // NOTE: each variable gets a default before any branch. Without the
    // default, a path that leaves it unassigned would infer a latch.
    next_state = state;
`ifdef BUFR_SEQ_TIMEOUT_EN
    timeout_nxt = timeout_q;
`endif
    if (bus.stop) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            next_state = WAIT_LOCK;
`ifdef BUFR_SEQ_TIMEOUT_EN
            timeout_nxt = 1'b0;
`endif
          end
        end
        WAIT_LOCK: begin
          if (lock) begin
            next_state = CLR_HOLD;
          end
`ifdef BUFR_SEQ_TIMEOUT_EN
          else if (cnt == WAIT_LAST) begin
            next_state  = IDLE;
            timeout_nxt = 1'b1;
          end
`endif
        end
        CLR_HOLD: begin
          if (!lock)                next_state = WAIT_LOCK;
          else if (cnt == CLR_LAST) next_state = CE_WAIT;
        end
        CE_WAIT: begin
          if (!lock)               next_state = WAIT_LOCK;
          else if (cnt == CE_LAST) next_state = SERDES_RST;
        end
        SERDES_RST: begin
          if (!lock)                 next_state = WAIT_LOCK;
          else if (cnt == SRST_LAST) next_state = READY;
        end
        READY: begin
          if (!lock) next_state = WAIT_LOCK;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // State, dwell counter, lock synchronizer and registered outputs. The
  // outputs are decoded from next_state, so they change on the same edge as
  // the state. bufr_clr and bufr_ce decode to disjoint state sets, so they
  // are never high together.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state     <= IDLE;
      cnt       <= '0;
      lock_sync <= '0;
      clr_q     <= 1'b1;
      ce_q      <= 1'b0;
      srst_q    <= 1'b1;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every flop
      // then samples the pre-edge values, regardless of statement order.
      state     <= next_state;
      cnt       <= (next_state != state) ? '0 : cnt + 16'd1;
      lock_sync <= {lock_sync[0], bus.locked};
      clr_q     <= next_state inside {IDLE, WAIT_LOCK, CLR_HOLD};
      ce_q      <= next_state inside {SERDES_RST, READY};
      srst_q    <= (next_state != READY);
      ready_q   <= (next_state == READY);
      busy_q    <= next_state inside {WAIT_LOCK, CLR_HOLD, CE_WAIT, SERDES_RST};
    end
  end

`ifdef BUFR_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) timeout_q <= 1'b0;
    else     timeout_q <= timeout_nxt;
  end
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.bufr_clr   = clr_q;
  assign bus.bufr_ce    = ce_q;
  assign bus.serdes_rst = srst_q;
  assign bus.ready      = ready_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_bufr_reset_sequencer.sv
// tb_bufr_reset_sequencer
//   Self-checking bench for bufr_reset_sequencer with CLR_CYCLES=4,
//   CE_DELAY=2, SERDES_RST_CYCLES=8 and LOCK_TIMEOUT=16.
//   The reference model views the bring-up as one timeline: the number of
//   cycles since lock was first seen. Each output is a function of that
//   timeline position. Outputs are sampled 1 time unit after each rising
//   clock edge.
module tb_bufr_reset_sequencer;
  localparam int C  = 4;
  localparam int D  = 2;
  localparam int S  = 8;
  localparam int LT = 16;

  logic clk = 1'b0;
  logic CLR;
  always #10 clk = ~clk;

  bufr_reset_sequencer_if bus ();

  bufr_reset_sequencer #(
    .CLR_CYCLES(C), .CE_DELAY(D), .SERDES_RST_CYCLES(S), .LOCK_TIMEOUT(LT)
  ) dut (
    .clk(clk),
    .CLR(CLR),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_OFF, M_WAIT, M_RUN} mode_t;
  mode_t m_mode;
  int    run_t;      // cycles since lock was first seen in this attempt
  int    wait_t;     // cycles spent waiting for lock
  bit    m_timeout;
  bit    lpipe[$];   // locked samples not yet visible after synchronization

`ifdef BUFR_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  function automatic void model_reset();
    m_mode = M_OFF; run_t = 0; wait_t = 0; m_timeout = 1'b0;
    lpipe.delete(); lpipe.push_back(1'b0); lpipe.push_back(1'b0);
  endfunction

  function automatic void model_edge(bit st, bit sp, bit lk);
    bit lock_seen;
    lock_seen = lpipe.pop_front();
    lpipe.push_back(lk);
    if (sp) begin
      m_mode = M_OFF;
    end else begin
      case (m_mode)
        M_OFF: if (st) begin m_mode = M_WAIT; wait_t = 0; m_timeout = 1'b0; end
        M_WAIT: begin
          if (lock_seen) begin m_mode = M_RUN; run_t = 0; end
          else if (TO_EN && wait_t == LT - 1) begin m_mode = M_OFF; m_timeout = 1'b1; end
          else wait_t++;
        end
        default: begin
          if (!lock_seen) begin m_mode = M_WAIT; wait_t = 0; end
          else if (run_t < C + D + S) run_t++;
        end
      endcase
    end
  endfunction

  // {bufr_clr, bufr_ce, serdes_rst, ready, busy, timeout}
  function automatic logic [5:0] model_out();
    logic [4:0] o;
    if (m_mode == M_OFF)       o = 5'b10100;
    else if (m_mode == M_WAIT) o = 5'b10101;
    else if (run_t < C)        o = 5'b10101;
    else if (run_t < C + D)    o = 5'b00101;
    else if (run_t < C + D + S) o = 5'b01101;
    else                       o = 5'b01010;
    return {o, m_timeout};
  endfunction

  function automatic logic [5:0] obs_vec();
    return {bus.bufr_clr, bus.bufr_ce, bus.serdes_rst, bus.ready, bus.busy, bus.timeout};
  endfunction

  // One clock cycle: drive on the falling edge, advance the model on the
  // rising edge, then compare the outputs and the structural invariants.
  task automatic step(input bit st, input bit sp, input bit lk);
    @(negedge clk);
    bus.start = st; bus.stop = sp; bus.locked = lk;
    @(posedge clk);
    model_edge(st, sp, lk);
    #1;
    check("outputs_vs_model", 32'(obs_vec()), 32'(model_out()));
    check("clr_and_ce_exclusive", 32'(bus.bufr_clr & bus.bufr_ce), 32'd0);
    check("ready_implies_ce_no_srst", 32'(bus.ready & ~(bus.bufr_ce & ~bus.serdes_rst)), 32'd0);
  endtask

  initial begin
    int n_clr, n_gap, n_srst, lat;
    bit got;
    CLR = 1'b1; bus.start = 1'b0; bus.stop = 1'b0; bus.locked = 1'b0;
    model_reset();
    #3;
    check("reset_outputs", 32'(obs_vec()), 32'b101000);
    @(negedge clk); @(negedge clk);
    CLR = 1'b0;

    // Steady lock, then a start pulse: measure each phase of the timeline.
    for (int i = 0; i < 4; i++) step(0, 0, 1);
    step(1, 0, 1);
    n_clr = (bus.bufr_clr) ? 1 : 0; n_gap = 0; n_srst = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(0, 0, 1);
      if (bus.ready) got = 1;
      else if (bus.bufr_clr) n_clr++;
      else if (!bus.bufr_ce) n_gap++;
      else if (bus.serdes_rst) n_srst++;
    end
    check("bringup_reached_ready", 32'(got), 32'd1);
    check("bufr_clr_cycles", 32'(n_clr), 32'(C + 1));
    check("both_low_cycles", 32'(n_gap), 32'(D));
    check("serdes_rst_cycles", 32'(n_srst), 32'(S));
    check("busy_low_when_ready", 32'(bus.busy), 32'd0);

    // Lock loss while ready: the outputs fall back to the clear phase after
    // the synchronizer delay.
    got = 0; lat = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      step(0, 0, 0); lat++;
      if (!bus.ready) got = 1;
    end
    check("lock_loss_latency", 32'(lat), 32'd3);
    check("lock_loss_state", 32'({bus.ready, bus.bufr_ce, bus.bufr_clr, bus.busy}), 32'b0011);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(0, 0, 1);
      if (bus.ready) got = 1;
    end
    check("relock_reaches_ready", 32'(got), 32'd1);

    // Stop and start together during CE_WAIT: stop wins, start is dropped.
    step(1, 1, 1);
    step(1, 0, 1);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (!bus.bufr_clr && !bus.bufr_ce && bus.busy) got = 1;
      else step(0, 0, 1);
    end
    check("reached_ce_wait", 32'(got), 32'd1);
    step(1, 1, 1);
    check("stop_forces_idle", 32'({bus.bufr_clr, bus.busy}), 32'b10);
    step(0, 0, 1);
    check("start_ignored_with_stop", 32'(bus.busy), 32'd0);

    // Lock wait without lock: a bounded wait with the timeout feature,
    // otherwise an unbounded wait.
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    step(1, 0, 0);
    lat = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(0, 0, 0); lat++;
      if (!bus.busy) got = 1;
    end
`ifdef BUFR_SEQ_TIMEOUT_EN
    check("timeout_fired", 32'({got, bus.timeout}), 32'b11);
    check("timeout_latency", 32'(lat), 32'(LT));
    step(1, 0, 0);
    check("start_clears_timeout", 32'({bus.timeout, bus.busy}), 32'b01);
    step(0, 1, 0);
`else
    check("no_timeout_waits_forever", 32'({got, bus.timeout, bus.busy}), 32'b001);
    step(0, 1, 0);
`endif

    // Asynchronous CLR pulse in SERDES_RST, between clock edges.
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    step(1, 0, 1);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(0, 0, 1);
      if (bus.bufr_ce && bus.serdes_rst) got = 1;
    end
    check("reached_serdes_rst", 32'(got), 32'd1);
    #1 CLR = 1'b1;
    #1 check("async_clr_outputs", 32'(obs_vec()), 32'b101000);
    #1 CLR = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) step(0, 0, 1);
    check("no_resume_after_clr", 32'({bus.busy, bus.bufr_clr}), 32'b01);

    // Randomized traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      bit st, sp, lk;
      st = ($urandom_range(0, 15) == 0);
      sp = ($urandom_range(0, 199) == 0);
      lk = ($urandom_range(0, 59) == 0) ? ~bus.locked : bus.locked;
      step(st, sp, lk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
